// File: rtl/soc_addr_pkg.sv
// Shared address map for the data SRAM port: config window base, register
// offsets, default RAM size and a byte-merge helper used by every writer.
package soc_addr_pkg;

    localparam logic [31:0] CONF_BASE      = 32'h1FAF_0000;
    localparam int          DEFAULT_RAM_AW = 14;

    localparam logic [15:0] OFF_LED        = 16'hF000;
    localparam logic [15:0] OFF_SWITCH     = 16'hF004;
    localparam logic [15:0] OFF_NUM        = 16'hF008;
    localparam logic [15:0] OFF_TIMER      = 16'hF00C;
    localparam logic [15:0] OFF_TIMER_CMP  = 16'hF010;
    localparam logic [15:0] OFF_INT_STATUS = 16'hF014;

    typedef enum logic [2:0] {
        REG_LED,
        REG_SWITCH,
        REG_NUM,
        REG_TIMER,
        REG_TIMER_CMP,
        REG_INT_STATUS,
        REG_NONE
    } confReg_e;

    // Map a window offset onto a register; anything else is unmapped.
    function automatic confReg_e decodeOffset(input logic [15:0] offset);
        case (offset)
            OFF_LED:        return REG_LED;
            OFF_SWITCH:     return REG_SWITCH;
            OFF_NUM:        return REG_NUM;
            OFF_TIMER:      return REG_TIMER;
            OFF_TIMER_CMP:  return REG_TIMER_CMP;
            OFF_INT_STATUS: return REG_INT_STATUS;
            default:        return REG_NONE;
        endcase
    endfunction

    // Replace only the bytes whose enable bit is set.
    function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                               input logic [31:0] newWord,
                                               input logic [3:0]  byteEn);
        logic [31:0] result;
        result = oldWord;
        for (int i = 0; i < 4; i++) begin
            if (byteEn[i]) result[8*i +: 8] = newWord[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// Core data SRAM port: request fields from the core, registered read data back.
interface data_sram_responder_if;

    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata
    );

endinterface

// File: rtl/bytewrite_ram.sv
// Single-port synchronous RAM with per-byte write enables. Read-first, so a
// write returns the word as it was before the write. The array is not reset
// so it maps onto block RAM.
module bytewrite_ram #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    wen,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    // Read the old word and merge the enabled bytes on the same edge.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            for (int i = 0; i < 4; i++) begin
                if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// Slave side of the core data SRAM port. Splits requests between the on-chip
// RAM and the config register window, runs the free-running timer and its
// sticky interrupt, and returns read data one cycle after the RAM read.
module data_sram_responder #(
    parameter int          RAM_AW    = soc_addr_pkg::DEFAULT_RAM_AW,
    parameter logic [31:0] CONF_BASE = soc_addr_pkg::CONF_BASE,
    parameter int          SW_W      = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    data_sram_responder_if.slave  bus,
    output logic [15:0]           led,
    input  logic [SW_W-1:0]       switch,
    output logic [31:0]           num_data,
    output logic                  timer_int
);

    import soc_addr_pkg::*;

    logic        confHit;
    confReg_e    reqReg;
    logic        confWrite;
    logic        ramEn;
    logic [31:0] ramQ;
    logic [31:0] ledMerged;
    logic [31:0] numMerged;
    logic [31:0] timerMerged;
    logic [31:0] cmpMerged;
    logic        intClear;

    logic [SW_W-1:0] swMeta;
    logic [SW_W-1:0] swSync;
    logic [31:0]     timer;
    logic [31:0]     timerCmp;

    logic        readPending;
    logic        confHitQ;
    confReg_e    regQ;
    logic [31:0] confReadData;
    logic [31:0] rdataQ;

    assign confHit   = (bus.data_sram_addr[31:16] == CONF_BASE[31:16]);
    assign reqReg    = decodeOffset(bus.data_sram_addr[15:0]);
    assign confWrite = bus.data_sram_en && confHit && (bus.data_sram_wen != 4'b0000);
    assign ramEn     = bus.data_sram_en && !confHit;

    assign ledMerged   = mergeBytes({16'h0000, led}, bus.data_sram_wdata, bus.data_sram_wen);
    assign numMerged   = mergeBytes(num_data, bus.data_sram_wdata, bus.data_sram_wen);
    assign timerMerged = mergeBytes(timer, bus.data_sram_wdata, bus.data_sram_wen);
    assign cmpMerged   = mergeBytes(timerCmp, bus.data_sram_wdata, bus.data_sram_wen);
    assign intClear    = confWrite && (reqReg == REG_INT_STATUS)
                         && bus.data_sram_wen[0] && bus.data_sram_wdata[0];

    bytewrite_ram #(
        .AW (RAM_AW)
    ) uRam (
        .clk   (clk),
        .en    (ramEn),
        .wen   (confHit ? 4'b0000 : bus.data_sram_wen),
        .addr  (bus.data_sram_addr[RAM_AW+1:2]),
        .wdata (bus.data_sram_wdata),
        .rdata (ramQ)
    );

    // Two-flop synchroniser for the asynchronous board switches.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            swMeta <= '0;
            swSync <= '0;
        end else begin
            swMeta <= switch;
            swSync <= swMeta;
        end
    end

    // Config registers and timer; a timer write overrides that cycle's increment.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led      <= '0;
            num_data <= '0;
            timer    <= '0;
            timerCmp <= '0;
        end else begin
            timer <= timer + 32'd1;
            if (confWrite) begin
                case (reqReg)
                    REG_LED:       led      <= ledMerged[15:0];
                    REG_NUM:       num_data <= numMerged;
                    REG_TIMER:     timer    <= timerMerged;
                    REG_TIMER_CMP: timerCmp <= cmpMerged;
                    default:       ;
                endcase
            end
        end
    end

    // Sticky interrupt: a compare hit on the pre-increment timer beats a clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_int <= 1'b0;
        end else if (timer == timerCmp) begin
            timer_int <= 1'b1;
        end else if (intClear) begin
            timer_int <= 1'b0;
        end
    end

    // Remember which target each request hit so the output mux can follow it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            readPending <= 1'b0;
            confHitQ    <= 1'b0;
            regQ        <= REG_NONE;
        end else begin
            readPending <= bus.data_sram_en;
            if (bus.data_sram_en) begin
                confHitQ <= confHit;
                regQ     <= reqReg;
            end
        end
    end

    // Config read mux driven by the registered offset.
    always_comb begin
        confReadData = 32'h0;
        case (regQ)
            REG_LED:        confReadData = {16'h0000, led};
            REG_SWITCH:     confReadData = 32'(swSync);
            REG_NUM:        confReadData = num_data;
            REG_TIMER:      confReadData = timer;
            REG_TIMER_CMP:  confReadData = timerCmp;
            REG_INT_STATUS: confReadData = {31'h0, timer_int};
            default:        confReadData = 32'h0;
        endcase
    end

    // Output register: loads only for a pending request, otherwise holds.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdataQ <= '0;
        end else if (readPending) begin
            rdataQ <= confHitQ ? confReadData : ramQ;
        end
    end

    assign bus.data_sram_rdata = rdataQ;

endmodule
